// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and amplitude helper for the CORDIC NCO front end.
// Optional build macro used by the users of this package: CORDIC_AMP_SCALE_EN.
package cordic_pkg;

  localparam int PHASE_W    = 32;
  localparam int AMP_W      = 16;
  localparam int CORDIC_LAT = 15;

  // 1/K = 0.60725 in Q1.15, pre-compensates the rotator gain
  localparam logic signed [AMP_W-1:0] GAIN_INIT = 16'sd19898;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } nco_state_t;

  // Q1.15 amplitude times gain compensation, arithmetic shift back to Q1.15
  function automatic logic [AMP_W-1:0] amp_scale(input logic signed [AMP_W-1:0] amp);
    logic signed [2*AMP_W-1:0] amp_w;
    logic signed [2*AMP_W-1:0] gain_w;
    logic signed [2*AMP_W-1:0] prod;
    amp_w  = amp;
    gain_w = GAIN_INIT;
    prod   = amp_w * gain_w;
    return AMP_W'(prod >>> 15);
  endfunction

endpackage

// File: rtl/cordic_nco_ctrl_if.sv
// Config/control/rotator-feed bundle for cordic_nco_ctrl.
// cfg_amp exists only when CORDIC_AMP_SCALE_EN is defined.
interface cordic_nco_ctrl_if;
  import cordic_pkg::*;

  // Handshake: a config word transfers on any clock edge where cfg_valid && cfg_ready;
  // cfg_ready is high only while idle, start/stop are single-cycle level strobes.
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [PHASE_W-1:0]        cfg_freq;
  logic [PHASE_W-1:0]        cfg_phase;
  logic [15:0]               cfg_count;
`ifdef CORDIC_AMP_SCALE_EN
  logic signed [AMP_W-1:0]   cfg_amp;
`endif
  logic                      start;
  logic                      stop;
  logic [PHASE_W-1:0]        angle;
  logic [AMP_W-1:0]          start1;
  logic [AMP_W-1:0]          start2;
  logic                      issue_valid;
  logic                      sample_valid;
  logic                      busy;
  logic                      done;
  nco_state_t                state_dbg;

  modport master (
    output cfg_valid, cfg_freq, cfg_phase, cfg_count,
`ifdef CORDIC_AMP_SCALE_EN
    output cfg_amp,
`endif
    output start, stop,
    input  cfg_ready, angle, start1, start2, issue_valid, sample_valid, busy, done, state_dbg
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_phase, cfg_count,
`ifdef CORDIC_AMP_SCALE_EN
    input  cfg_amp,
`endif
    input  start, stop,
    output cfg_ready, angle, start1, start2, issue_valid, sample_valid, busy, done, state_dbg
  );

endinterface

// File: rtl/cordic_valid_pipe.sv
// Fixed-depth 1-bit valid shift register with synchronous clear; tracks data through
// a latency-matched datapath and reports when it will be empty after this edge.
module cordic_valid_pipe #(
  parameter int DEPTH = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic din,
  output logic dout,
  output logic empty_next
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign shift_d = din;
    end else begin : g_multi
      assign shift_d = {shift_q[DEPTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || clear) shift_q <= '0;
    else                shift_q <= shift_d;
  end

  assign dout       = shift_q[DEPTH-1];
  assign empty_next = ~|shift_d;

endmodule

// File: rtl/cordic_nco_ctrl.sv
// NCO front end: phase accumulator feeding a pipelined CORDIC rotator, with burst and
// continuous modes. Build macro: CORDIC_AMP_SCALE_EN adds a latched amplitude for start1.
module cordic_nco_ctrl
  import cordic_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cordic_nco_ctrl_if.slave nco
);

  nco_state_t          state_q, state_d;
  logic [PHASE_W-1:0]  freq_q, phase_q, angle_q;
  logic [15:0]         count_q, issued_q;
  logic [AMP_W-1:0]    start1_q;
  logic                issue_q, busy_q, done_q, ready_q;
  logic                last_issue, pipe_empty_next, sample_valid_w;
  logic                cfg_take;

  assign cfg_take   = ready_q && nco.cfg_valid;
  // Stop and burst-end land on the same edge, so both collapse into one transition
  assign last_issue = nco.stop || ((count_q != 16'd0) && (issued_q == count_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (nco.start)      state_d = RUN;
      RUN:     if (last_issue)     state_d = DRAIN;
      DRAIN:   if (pipe_empty_next) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      freq_q   <= '0;
      phase_q  <= '0;
      count_q  <= '0;
      angle_q  <= '0;
      issued_q <= '0;
      start1_q <= GAIN_INIT;
      issue_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      issue_q <= (state_d == RUN);
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);

      if (cfg_take) begin
        freq_q  <= nco.cfg_freq;
        phase_q <= nco.cfg_phase;
        count_q <= nco.cfg_count;
`ifdef CORDIC_AMP_SCALE_EN
        start1_q <= amp_scale(nco.cfg_amp);
`endif
      end

      case (state_q)
        IDLE: begin
          // A config offered alongside start is forwarded straight into the first angle
          if (nco.start) begin
            angle_q  <= cfg_take ? nco.cfg_phase : phase_q;
            issued_q <= 16'd1;
          end
        end
        RUN: begin
          if (!last_issue) begin
            angle_q <= angle_q + freq_q;
            if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  cordic_valid_pipe #(.DEPTH(CORDIC_LAT)) u_valid_pipe (
    .clock      (clock),
    .reset      (reset),
    .clear      (1'b0),
    .din        (issue_q),
    .dout       (sample_valid_w),
    .empty_next (pipe_empty_next)
  );

  assign nco.cfg_ready    = ready_q;
  assign nco.angle        = angle_q;
  assign nco.start1       = start1_q;
  assign nco.start2       = '0;
  assign nco.issue_valid  = issue_q;
  assign nco.sample_valid = sample_valid_w;
  assign nco.busy         = busy_q;
  assign nco.done         = done_q;
  assign nco.state_dbg    = state_q;

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
// Scoreboard bench for cordic_nco_ctrl: directed bursts push expected angles and
// expected issue/sample/done cycles; a negedge monitor pops and compares.
module tb_cordic_nco_ctrl;
  import cordic_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_angle_q[$];
  logic [31:0] exp_icyc_q[$];
  logic [31:0] exp_scyc_q[$];
  logic [31:0] exp_dcyc_q[$];
  logic [15:0] exp_start1;

  cordic_nco_ctrl_if nco_if ();

  cordic_nco_ctrl dut (
    .clock (clock),
    .reset (reset),
    .nco   (nco_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers a config then start (or both in one cycle); returns the start cycle
  task automatic launch(input logic [31:0] f, input logic [31:0] p, input logic [15:0] n,
                        input bit forward, output int k);
    nco_if.cfg_valid = 1'b1;
    nco_if.cfg_freq  = f;
    nco_if.cfg_phase = p;
    nco_if.cfg_count = n;
    if (!forward) begin
      tick();
      nco_if.cfg_valid = 1'b0;
    end
    nco_if.start = 1'b1;
    k = cyc;
    tick();
    nco_if.start     = 1'b0;
    nco_if.cfg_valid = 1'b0;
  endtask

  task automatic expect_cycles(input int k, input int n, input bit with_drain);
    for (int i = 0; i < n; i++) begin
      exp_icyc_q.push_back(32'(k + 1 + i));
      if (with_drain) exp_scyc_q.push_back(32'(k + 1 + CORDIC_LAT + i));
    end
    if (with_drain) exp_dcyc_q.push_back(32'(k + 1 + n + CORDIC_LAT));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_dcyc_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_dcyc_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: done not seen, %0d expected events pending", name,
               exp_dcyc_q.size());
      exp_dcyc_q.delete();
    end
    tick();
    check({name, "_angles_left"}, 32'(exp_angle_q.size()), 32'd0);
    check({name, "_samples_left"}, 32'(exp_scyc_q.size()), 32'd0);
    check({name, "_idle_ready"}, {31'd0, nco_if.cfg_ready}, 32'd1);
    exp_angle_q.delete();
    exp_icyc_q.delete();
    exp_scyc_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (nco_if.issue_valid === 1'b1) begin
      if (exp_angle_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL issue_unexpected: issue_valid=1 angle %h (cycle %0d)", nco_if.angle, cyc);
      end else begin
        check("angle", nco_if.angle, exp_angle_q.pop_front());
        check("issue_cycle", 32'(cyc), exp_icyc_q.pop_front());
        check("start1", {16'd0, nco_if.start1}, {16'd0, exp_start1});
        check("start2", {16'd0, nco_if.start2}, 32'd0);
      end
    end
    if (nco_if.sample_valid === 1'b1) begin
      if (exp_scyc_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sample_unexpected: sample_valid=1 (cycle %0d)", cyc);
      end else begin
        check("sample_cycle", 32'(cyc), exp_scyc_q.pop_front());
      end
    end
    if (nco_if.done === 1'b1) begin
      if (exp_dcyc_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL done_unexpected: done=1 (cycle %0d)", cyc);
      end else begin
        check("done_cycle", 32'(cyc), exp_dcyc_q.pop_front());
        check("done_busy", {31'd0, nco_if.busy}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [31:0] t1_angles[4];
    t1_angles[0] = 32'h0000_0000;
    t1_angles[1] = 32'h4000_0000;
    t1_angles[2] = 32'h8000_0000;
    t1_angles[3] = 32'hC000_0000;

    nco_if.cfg_valid = 1'b0;
    nco_if.cfg_freq  = '0;
    nco_if.cfg_phase = '0;
    nco_if.cfg_count = '0;
    nco_if.start     = 1'b0;
    nco_if.stop      = 1'b0;
`ifdef CORDIC_AMP_SCALE_EN
    nco_if.cfg_amp   = 16'sh4000;
    exp_start1       = 16'd9949;
`else
    exp_start1       = 16'd19898;
`endif

    repeat (3) tick();
    reset = 1'b0;
    check("rst_angle", nco_if.angle, 32'd0);
    check("rst_start1", {16'd0, nco_if.start1}, 32'd19898);
    check("rst_start2", {16'd0, nco_if.start2}, 32'd0);
    check("rst_issue", {31'd0, nco_if.issue_valid}, 32'd0);
    check("rst_sample", {31'd0, nco_if.sample_valid}, 32'd0);
    check("rst_busy", {31'd0, nco_if.busy}, 32'd0);
    check("rst_done", {31'd0, nco_if.done}, 32'd0);
    check("rst_ready", {31'd0, nco_if.cfg_ready}, 32'd1);
    check("rst_state", {30'd0, nco_if.state_dbg}, {30'd0, IDLE});

    // Quarter-turn burst of 4
    for (int i = 0; i < 4; i++) exp_angle_q.push_back(t1_angles[i]);
    launch(32'h4000_0000, 32'h0000_0000, 16'd4, 1'b0, k);
    expect_cycles(k, 4, 1'b1);
    check("t1_busy", {31'd0, nco_if.busy}, 32'd1);
    wait_drain("t1");

    // Phase wrap across 2^32
    exp_angle_q.push_back(32'hFFFF_FFF0);
    exp_angle_q.push_back(32'h0000_0010);
    launch(32'h0000_0020, 32'hFFFF_FFF0, 16'd2, 1'b0, k);
    expect_cycles(k, 2, 1'b1);
    wait_drain("t2");

    // Continuous, stop asserted during the 10th issued sample
    for (int i = 0; i < 10; i++) exp_angle_q.push_back(32'h0800_0000 + 32'(i) * 32'h1000_0000);
    launch(32'h1000_0000, 32'h0800_0000, 16'd0, 1'b0, k);
    expect_cycles(k, 10, 1'b1);
    repeat (9) tick();
    nco_if.stop = 1'b1;
    tick();
    nco_if.stop = 1'b0;
    wait_drain("t3");

    // Stop coinciding with the final burst sample
    exp_angle_q.push_back(32'h0000_1000);
    exp_angle_q.push_back(32'h0000_1100);
    exp_angle_q.push_back(32'h0000_1200);
    launch(32'h0000_0100, 32'h0000_1000, 16'd3, 1'b0, k);
    expect_cycles(k, 3, 1'b1);
    tick();
    tick();
    nco_if.stop = 1'b1;
    tick();
    nco_if.stop = 1'b0;
    wait_drain("t3b");

    // Forwarded config with start; config offered mid-run is refused
    for (int i = 0; i < 6; i++) exp_angle_q.push_back(32'd5 + 32'(i));
    launch(32'd1, 32'd5, 16'd6, 1'b1, k);
    expect_cycles(k, 6, 1'b1);
    tick();
    nco_if.cfg_valid = 1'b1;
    nco_if.cfg_freq  = 32'd100;
    nco_if.cfg_phase = 32'd999;
    nco_if.cfg_count = 16'd1;
    check("t4_ready_run", {31'd0, nco_if.cfg_ready}, 32'd0);
    nco_if.start = 1'b1;
    tick();
    nco_if.cfg_valid = 1'b0;
    nco_if.start     = 1'b0;
    wait_drain("t4");

    // Reset three cycles into a continuous run
    for (int i = 0; i < 3; i++) exp_angle_q.push_back(32'(i) * 32'd7);
    launch(32'd7, 32'd0, 16'd0, 1'b0, k);
    expect_cycles(k, 3, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", {31'd0, nco_if.busy}, 32'd0);
    check("t5_issue", {31'd0, nco_if.issue_valid}, 32'd0);
    check("t5_angle", nco_if.angle, 32'd0);
    check("t5_ready", {31'd0, nco_if.cfg_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("t5_sample_quiet", {31'd0, nco_if.sample_valid}, 32'd0);
      check("t5_done_quiet", {31'd0, nco_if.done}, 32'd0);
      tick();
    end
    check("t5_angles_left", 32'(exp_angle_q.size()), 32'd0);

    // Amplitude path after a fresh latch
    exp_angle_q.push_back(32'd0);
    launch(32'd0, 32'd0, 16'd1, 1'b0, k);
    expect_cycles(k, 1, 1'b1);
`ifdef CORDIC_AMP_SCALE_EN
    check("t6_start1", {16'd0, nco_if.start1}, 32'd9949);
`else
    check("t6_start1", {16'd0, nco_if.start1}, 32'd19898);
`endif
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $finish;
  end

endmodule

// File: doc/cordic_nco_ctrl.md
Name: cordic_nco_ctrl

Overview:
- Upstream feeder for the 15-stage pipelined CORDIC rotator; a numerically controlled oscillator front end.
- Phase accumulator issues one angle per cycle with constant start vectors (start1 = CORDIC gain compensation, start2 = 0), so the rotator emits cos/sin of the running phase.
- Tracks rotator latency with a valid shift pipeline: sample_valid marks exactly the cycles where rotator sine/cosine are meaningful.
- Supports burst (N samples) and continuous modes, with a done pulse after drain.

Parameters:
- PHASE_W, 32, angle/phase/frequency word width (binary angle: 2^32 = 2*pi)
- AMP_W, 16, start vector width
- CORDIC_LAT, 15, cycles from angle presented to rotator outputs valid
- GAIN_INIT, 16'sd19898, 1/K = 0.60725 in Q1.15

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  high only in IDLE
- cfg_freq  in  PHASE_W  phase increment per sample
- cfg_phase  in  PHASE_W  initial phase
- cfg_count  in  16  samples per burst; 0 = continuous
- start  in  1  begin issuing (IDLE only)
- stop  in  1  end issuing early (RUN only)
- angle  out  PHASE_W  to rotator angle input
- start1  out  AMP_W  to rotator start1
- start2  out  AMP_W  to rotator start2, always 0
- issue_valid  out  1  angle is a real sample this cycle
- sample_valid  out  1  rotator sine/cosine valid this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when drain completes

Behaviour:
- One clock; reset synchronous, active-high; all outputs registered.
- Reset values: state IDLE, angle 0, start1 GAIN_INIT, start2 0, issue_valid 0, sample_valid 0, busy 0, done 0, cfg_ready 1. Latched freq/phase/count = 0. Valid pipe flushed.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_valid && cfg_ready latches freq/phase/count.
  - start -> RUN. If cfg_valid and start arrive in the same cycle, the new config is used (forwarded).
  - stop ignored.
- RUN:
  - First issue cycle is the cycle after start: angle = phase, issue_valid = 1.
  - Each following cycle: angle += freq, wrapping mod 2^PHASE_W with no saturation; issued counter +1.
  - count != 0: after the count-th sample is issued, the next cycle enters DRAIN with issue_valid = 0.
  - stop: the current cycle's sample still issues; the next cycle enters DRAIN.
  - stop coinciding with the last burst sample gives a single transition.
  - start and cfg_valid ignored (cfg_ready = 0).
  - count = 0 runs until stop; issued counter saturates and does not wrap.
- DRAIN:
  - issue_valid = 0; angle holds its last value.
  - Waits until the valid pipe is empty, then: done = 1 for one cycle, busy drops, state -> IDLE in that same cycle.
  - start and stop ignored.
- Valid pipe:
  - CORDIC_LAT-deep shift register; input issue_valid, output sample_valid.
  - sample_valid is issue_valid delayed by exactly CORDIC_LAT cycles.
- Reset mid-RUN or mid-DRAIN: immediate return to reset values; no done pulse; in-flight sample_valid bits discarded.

Optional Feature:
- Macro: CORDIC_AMP_SCALE_EN.
- Defined:
  - Adds input cfg_amp (AMP_W, signed Q1.15), latched with the config.
  - start1 = (cfg_amp * GAIN_INIT) >>> 15, truncated to AMP_W, computed at latch time.
  - Reset value of cfg_amp is 16'sh7FFF.
- Undefined: no cfg_amp port; start1 is constant GAIN_INIT.

Decomposition:
- Package cordic_pkg: CORDIC_LAT, GAIN_INIT, PHASE_W, AMP_W constants; state enum typedef nco_state_t {IDLE, RUN, DRAIN}.
- Sub-module cordic_valid_pipe: parameterised-depth 1-bit shift register with synchronous clear, reused later on the rotator output side.

Test Plan:
1. Reset, then cfg freq=32'h4000_0000, phase=0, count=4, start -> angles 0, 4000_0000, 8000_0000, C000_0000 with issue_valid=1 for 4 cycles. sample_valid=1 for the 4 cycles starting 15 cycles after the first issue. done pulse on the cycle the pipe empties.
2. Wrap: phase=32'hFFFF_FFF0, freq=32'h20, count=2 -> angles FFFF_FFF0, 0000_0010.
3. Continuous: count=0, start, stop after 10 issued samples (stop asserted during the 10th) -> exactly 10 issue_valid cycles, 10 sample_valid cycles, then done.
4. Same-cycle cfg_valid+start in IDLE with freq=1, phase=5 -> first angle 5. cfg_valid during RUN -> cfg_ready=0, accumulator unaffected.
5. Reset asserted 3 cycles into RUN -> next cycle busy=0, issue_valid=0, sample_valid=0 for the following 20 cycles, no done pulse.
6. With CORDIC_AMP_SCALE_EN, cfg_amp=16'sh4000 -> start1 = 9949. Without it, start1 = 19898 and start2 = 0 throughout.
